// File: rtl/cmd_pkg.sv
// cmd_pkg: shared definitions for the command write-side arbitration slice.
//   CMD_WIDTH_DEF / CMD_BEAT_W : default beat width in bytes / bits
//   MAX_BEATS_DEF              : default packet length limit before forced release
//   state_e                    : arbiter state encoding (ST_IDLE, ST_LOCK)
//   clog2_min1()               : index/counter width helper, never below 1 bit
package cmd_pkg;

  localparam int unsigned CMD_WIDTH_DEF = 256;
  localparam int unsigned CMD_BEAT_W    = 8 * CMD_WIDTH_DEF;
  localparam int unsigned MAX_BEATS_DEF = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cmd_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req        in  NREQ  request vector
//   last_grant in  IDW   most recent winner; search starts just after it
//   winner     out IDW   first set request found circularly from last_grant+1
//   found      out 1     at least one request is set
module rr_pick
  import cmd_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [IDW-1:0]  winner,
  output logic            found
);

  // Offsets are scanned in increasing distance from last_grant, so the
  // first hit is the highest-priority requester this round.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!found && req[j] && (j == (32'(last_grant) + off) % NREQ)) begin
          winner = IDW'(j);
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cmd_wr_arbiter.sv
// cmd_wr_arbiter: round-robin owner of the single command FIFO write port.
// A requester keeps the grant for a whole packet so packets never interleave.
//   CLK, rst_n     clock, asynchronous active-low reset
//   req_valid/last per-requester beat valid and last-beat flag
//   req_data       per-requester beat, requester i at [i*8*WIDTH +: 8*WIDTH]
//   req_ready      per-requester beat accepted (combinational)
//   fifo_full      FIFO full flag; fifo_wr_en/fifo_data drive the FIFO write side
//   grant_id, busy current owner (registered) and LOCK indication
//   err_overlong   sticky: a packet reached MAX_BEATS without last; err_id = first culprit
//   err_clr        synchronous clear of err_overlong/err_id (a same-cycle set wins)
module cmd_wr_arbiter
  import cmd_pkg::*;
#(
  parameter  int unsigned NREQ      = 4,
  parameter  int unsigned WIDTH     = CMD_BEAT_W / 8,
  parameter  int unsigned MAX_BEATS = MAX_BEATS_DEF,
  localparam int unsigned IDW       = clog2_min1(NREQ)
) (
  input  logic                    CLK,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_last,
  input  logic [NREQ*8*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    fifo_full,
  output logic                    fifo_wr_en,
  output logic [8*WIDTH-1:0]      fifo_data,
  output logic [IDW-1:0]          grant_id,
  output logic                    busy,
  output logic                    err_overlong,
  output logic [IDW-1:0]          err_id,
  input  logic                    err_clr
);

  localparam int unsigned BW = 8 * WIDTH;
  localparam int unsigned CW = clog2_min1(MAX_BEATS);

  state_e          state_q, state_d;
  logic [IDW-1:0]  grant_q, grant_d;
  logic [IDW-1:0]  last_grant_q, last_grant_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            err_q, err_d;
  logic [IDW-1:0]  err_id_q, err_id_d;

  logic [IDW-1:0]  pick_id;
  logic            pick_found;
  logic [BW-1:0]   beat [NREQ];
  logic            at_limit;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .winner     (pick_id),
    .found      (pick_found)
  );

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      beat[i] = req_data[i*BW +: BW];
    end
  end

  assign at_limit = (beat_cnt_q == CW'(MAX_BEATS - 1));

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    err_d        = err_q;
    err_id_d     = err_id_q;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;

    if (err_clr) begin
      err_d    = 1'b0;
      err_id_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = pick_id;
          state_d = ST_LOCK;
        end
      end
      ST_LOCK: begin
        req_ready[grant_q] = !fifo_full;
        fifo_wr_en         = req_valid[grant_q] && !fifo_full;
        if (fifo_wr_en) begin
          if (req_last[grant_q] || at_limit) begin
            state_d      = ST_IDLE;
            last_grant_d = grant_q;
            beat_cnt_d   = '0;
            // Forced release; the overlong set overrides a same-cycle clear,
            // and a clear also re-arms capture of the culprit id.
            if (!req_last[grant_q]) begin
              err_d = 1'b1;
              if (!err_q || err_clr) begin
                err_id_d = grant_q;
              end
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDW'(NREQ - 1);
      beat_cnt_q   <= '0;
      err_q        <= 1'b0;
      err_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      err_q        <= err_d;
      err_id_q     <= err_id_d;
    end
  end

  assign fifo_data    = beat[grant_q];
  assign grant_id     = grant_q;
  assign busy         = (state_q == ST_LOCK);
  assign err_overlong = err_q;
  assign err_id       = err_id_q;

endmodule

// File: tb/tb_cmd_wr_arbiter.sv
// tb_cmd_wr_arbiter: directed scenarios followed by a randomized phase, checked
// every cycle against a packet-level reference model (owner, round-robin
// pointer, beats taken in the current grant, sticky error).
module tb_cmd_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int MAXB  = 4;
  localparam int BW    = 8 * WIDTH;
  localparam int IDW   = 2;

  logic                 CLK = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_last;
  logic [NREQ*BW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 fifo_full;
  logic                 fifo_wr_en;
  logic [BW-1:0]        fifo_data;
  logic [IDW-1:0]       grant_id;
  logic                 busy;
  logic                 err_overlong;
  logic [IDW-1:0]       err_id;
  logic                 err_clr;

  always #5 CLK = ~CLK;

  cmd_wr_arbiter #(
    .NREQ      (NREQ),
    .WIDTH     (WIDTH),
    .MAX_BEATS (MAXB)
  ) dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data    (fifo_data),
    .grant_id     (grant_id),
    .busy         (busy),
    .err_overlong (err_overlong),
    .err_id       (err_id),
    .err_clr      (err_clr)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int owner   = -1;
  int grant_m = 0;
  int lastg   = NREQ - 1;
  int cnt     = 0;
  int eid     = 0;
  bit err_m   = 1'b0;

  // Requester sources
  int sent [NREQ];
  int plen [NREQ];
  int next_len [NREQ];
  int pkt [NREQ];
  bit want [NREQ];
  bit oneshot [NREQ];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]          = want[i];
      req_last[i]           = (sent[i] == plen[i] - 1);
      req_data[i*BW +: BW]  = {8'(i), 8'(pkt[i]), 16'(sent[i])};
    end
  endtask

  function automatic int rr_model();
    for (int k = 1; k <= NREQ; k++) begin
      if (want[(lastg + k) % NREQ]) return (lastg + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic bit all_idle();
    all_idle = (owner < 0);
    for (int i = 0; i < NREQ; i++) if (want[i]) all_idle = 1'b0;
  endfunction

  // One clock: compare at the falling edge, advance the model, then drive
  // the next inputs just after the rising edge.
  task automatic step();
    logic [NREQ-1:0] exp_ready;
    logic            exp_wr;
    int              cur, w;
    bit              set_err, lst;
    @(negedge CLK);
    exp_ready = '0;
    exp_wr    = 1'b0;
    if (owner >= 0) begin
      exp_ready[owner] = !fifo_full;
      exp_wr           = want[owner] && !fifo_full;
    end
    check("busy", busy, (owner >= 0));
    check("grant_id", grant_id, grant_m);
    check("req_ready", req_ready, exp_ready);
    check("fifo_wr_en", fifo_wr_en, exp_wr);
    check("err_overlong", err_overlong, err_m);
    check("err_id", err_id, eid);
    if (exp_wr) check("fifo_data", fifo_data, {8'(owner), 8'(pkt[owner]), 16'(sent[owner])});

    cur     = owner;
    set_err = 1'b0;
    if (owner < 0) begin
      w = rr_model();
      if (w >= 0) begin
        owner   = w;
        grant_m = w;
        cnt     = 0;
      end
    end else if (exp_wr) begin
      lst = (sent[cur] == plen[cur] - 1);
      cnt++;
      if (lst) begin
        sent[cur] = 0;
        pkt[cur]++;
        plen[cur] = next_len[cur];
        if (oneshot[cur]) want[cur] = 1'b0;
      end else begin
        sent[cur]++;
      end
      if (lst || cnt == MAXB) begin
        lastg   = cur;
        owner   = -1;
        cnt     = 0;
        set_err = !lst;
      end
    end
    if (set_err) begin
      if (!err_m || err_clr) eid = cur;
      err_m = 1'b1;
    end else if (err_clr) begin
      err_m = 1'b0;
      eid   = 0;
    end
    @(posedge CLK);
    #1;
    drive();
  endtask

  task automatic wait_beat(input int r, input int s);
    for (int k = 0; k < 100; k++) begin
      if (owner == r && sent[r] == s) break;
      step();
    end
    check("wait_timeout", (owner == r && sent[r] == s), 1);
  endtask

  // Let every pending packet finish, then leave all requesters idle.
  task automatic drain();
    fifo_full = 1'b0;
    err_clr   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      oneshot[i] = 1'b1;
      if (sent[i] > 0 || owner == i) want[i] = 1'b1;
    end
    drive();
    for (int k = 0; k < 200; k++) begin
      if (all_idle()) break;
      step();
    end
    check("drain_timeout", all_idle(), 1);
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      sent[i] = 0; plen[i] = 1; next_len[i] = 1; pkt[i] = 0;
      want[i] = 1'b1; oneshot[i] = 1'b1;
    end
    rst_n     = 1'b0;
    fifo_full = 1'b0;
    err_clr   = 1'b0;
    drive();
    #12;
    check("rst_ready", req_ready, 4'b0000);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    check("rst_err", err_overlong, 0);
    check("rst_err_id", err_id, 0);
    for (int i = 0; i < NREQ; i++) want[i] = 1'b0;
    drive();
    @(posedge CLK);
    #1;
    rst_n = 1'b1;

    // Single 3-beat packet from requester 0
    plen[0] = 3; next_len[0] = 3; want[0] = 1'b1;
    drive();
    drain();

    // All requesters continuously valid with 1-beat packets
    for (int i = 0; i < NREQ; i++) begin
      plen[i] = 1; next_len[i] = 1; oneshot[i] = 1'b0; want[i] = 1'b1;
    end
    drive();
    repeat (12) step();
    drain();

    // FIFO full for 5 cycles while requester 2 is mid-packet
    plen[2] = 4; next_len[2] = 1; want[2] = 1'b1;
    drive();
    wait_beat(2, 1);
    fifo_full = 1'b1;
    drive();
    repeat (5) step();
    fifo_full = 1'b0;
    drive();
    drain();

    // Requester 1 overruns MAX_BEATS, requester 3 waits behind it
    plen[1] = 6; next_len[1] = 1; want[1] = 1'b1;
    drive();
    wait_beat(1, 0);
    plen[3] = 1; next_len[3] = 1; want[3] = 1'b1;
    drive();
    drain();
    err_clr = 1'b1;
    drive();
    step();
    err_clr = 1'b0;
    drive();
    step();

    // Asynchronous reset during beat 2 of requester 3
    plen[3] = 4; next_len[3] = 1; want[3] = 1'b1;
    drive();
    wait_beat(3, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_wr_en", fifo_wr_en, 0);
    check("arst_ready", req_ready, 4'b0000);
    check("arst_grant", grant_id, 0);
    owner = -1; grant_m = 0; lastg = NREQ - 1; cnt = 0; err_m = 1'b0; eid = 0;
    for (int i = 0; i < NREQ; i++) begin
      sent[i] = 0; plen[i] = 1; next_len[i] = 1; want[i] = 1'b0;
    end
    want[0] = 1'b1; want[3] = 1'b1;
    drive();
    @(posedge CLK);
    #1;
    rst_n = 1'b1;
    step();
    check("post_rst_winner", grant_id, 0);
    drain();

    // Owner 1 drops valid for 3 cycles while requester 0 waits
    plen[1] = 3; next_len[1] = 1; want[1] = 1'b1;
    drive();
    wait_beat(1, 1);
    plen[0] = 1; want[0] = 1'b1; want[1] = 1'b0;
    drive();
    repeat (3) step();
    want[1] = 1'b1; plen[2] = 1; want[2] = 1'b1;
    drive();
    drain();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        oneshot[i]  = 1'b0;
        want[i]     = ($urandom_range(9) < 6);
        next_len[i] = 1 + $urandom_range(5);
      end
      fifo_full = ($urandom_range(3) == 0);
      err_clr   = ($urandom_range(29) == 0);
      drive();
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
